// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its history table.
package branch_pkg;

  localparam int unsigned OPERATION_SIZE = 3;

  typedef enum logic [OPERATION_SIZE-1:0] {
    OP_JAL  = 3'd0,
    OP_JALR = 3'd1,
    OP_BEQ  = 3'd2,
    OP_BNE  = 3'd3,
    OP_BLT  = 3'd4,
    OP_BGE  = 3'd5,
    OP_BLTU = 3'd6,
    OP_BGEU = 3'd7
  } branch_op_e;

  localparam int unsigned PC_INCREMENT = 4;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

  // Two-bit saturating counter step: taken counts up to 3, not-taken down to 0.
  function automatic bht_ctr_t bht_ctr_next(bht_ctr_t ctr, logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response and BHT lookup bundle between execute, the resolve unit and fetch.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned OFFSET_SIZE     = 12,
  parameter int unsigned JAL_OFFSET_SIZE = 20,
  parameter int unsigned OPERATION_SIZE  = 3
);
  logic                       in_valid;
  logic                       in_ready;
  logic [OPERATION_SIZE-1:0]  operation;
  logic [OFFSET_SIZE-1:0]     offset;
  logic [JAL_OFFSET_SIZE-1:0] jal_offset;
  logic [XLEN-1:0]            data_in1;
  logic [XLEN-1:0]            data_in2;
  logic [XLEN-1:0]            address_in;
  logic                       pred_taken;
  logic [XLEN-1:0]            pred_target;
  logic                       flush;
  logic                       out_valid;
  logic                       out_ready;
  logic [XLEN-1:0]            address_out;
  logic [XLEN-1:0]            link_address;
  logic                       taken;
  logic                       mispredict;
  logic [XLEN-1:0]            lookup_pc;
  logic                       lookup_taken;

  modport master (
    output in_valid, operation, offset, jal_offset, data_in1, data_in2,
           address_in, pred_taken, pred_target, flush, out_ready, lookup_pc,
    input  in_ready, out_valid, address_out, link_address, taken, mispredict,
           lookup_taken
  );

  modport slave (
    input  in_valid, operation, offset, jal_offset, data_in1, data_in2,
           address_in, pred_taken, pred_target, flush, out_ready, lookup_pc,
    output in_ready, out_valid, address_out, link_address, taken, mispredict,
           lookup_taken
  );
endinterface

// File: rtl/branch_resolve_unit_bht.sv
// Direct-mapped bimodal branch history table: async read for fetch, one
// saturating update per cycle from resolution.
module branch_history_table
  import branch_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned BHT_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_IDX_W-1:0] lookup_idx,
  output logic                 lookup_taken,
  input  logic                 upd_en,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  bht_ctr_t ctr_q [BHT_DEPTH];

  // Counter array: all entries weakly not-taken on reset, trained on update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        ctr_q[i] <= BHT_CTR_RESET;
      end
    end else if (upd_en) begin
      ctr_q[upd_idx] <= bht_ctr_next(ctr_q[upd_idx], upd_taken);
    end
  end

  // Read comes from the registered array, so a same-cycle write is not visible.
  assign lookup_taken = ctr_q[lookup_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// One-stage registered resolver for JAL/JALR/B-type transfers with
// valid/ready handshake, misprediction detection and BHT training.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned OFFSET_SIZE     = 12,
  parameter int unsigned JAL_OFFSET_SIZE = 20,
  parameter int unsigned OPERATION_SIZE  = 3,
  parameter int unsigned BHT_DEPTH       = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned BHT_IDX_W = $clog2(BHT_DEPTH);

  logic            out_valid_q;
  logic [XLEN-1:0] address_out_q;
  logic [XLEN-1:0] link_address_q;
  logic            taken_q;
  logic            mispredict_q;

  logic            xfer;
  logic            op_defined;
  branch_op_e      op;

  logic [XLEN-1:0] link_c;
  logic [XLEN-1:0] jal_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] tgt_c;
  logic [XLEN-1:0] next_pc_c;
  logic [XLEN-1:0] pred_pc_c;
  logic            taken_c;
  logic            is_branch_c;
  logic            mispredict_c;

  assign bus.in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
  assign xfer         = bus.in_valid && bus.in_ready;

  // Codes above the 3-bit space only exist when the opcode field is widened.
  generate
    if (OPERATION_SIZE > 3) begin : g_wide_op
      assign op_defined = ~|bus.operation[OPERATION_SIZE-1:3];
    end else begin : g_narrow_op
      assign op_defined = 1'b1;
    end
  endgenerate

  assign op = branch_op_e'(bus.operation[2:0]);

  assign link_c   = bus.address_in + XLEN'(PC_INCREMENT);
  assign jal_tgt  = bus.address_in +
                    {{(XLEN-JAL_OFFSET_SIZE-1){bus.jal_offset[JAL_OFFSET_SIZE-1]}},
                     bus.jal_offset, 1'b0};
  assign jalr_sum = bus.data_in1 +
                    {{(XLEN-OFFSET_SIZE){bus.offset[OFFSET_SIZE-1]}}, bus.offset};
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
  assign br_tgt   = bus.address_in +
                    {{(XLEN-OFFSET_SIZE-1){bus.offset[OFFSET_SIZE-1]}}, bus.offset, 1'b0};

  // Decode the operation into a taken decision, target and BHT-update qualifier.
  always_comb begin
    taken_c     = 1'b0;
    is_branch_c = 1'b0;
    tgt_c       = br_tgt;
    case (op)
      OP_JAL: begin
        taken_c = 1'b1;
        tgt_c   = jal_tgt;
      end
      OP_JALR: begin
        taken_c = 1'b1;
        tgt_c   = jalr_tgt;
      end
      OP_BEQ: begin
        is_branch_c = 1'b1;
        taken_c     = (bus.data_in1 == bus.data_in2);
      end
      OP_BNE: begin
        is_branch_c = 1'b1;
        taken_c     = (bus.data_in1 != bus.data_in2);
      end
      OP_BLT: begin
        is_branch_c = 1'b1;
        taken_c     = ($signed(bus.data_in1) < $signed(bus.data_in2));
      end
      OP_BGE: begin
        is_branch_c = 1'b1;
        taken_c     = ($signed(bus.data_in1) >= $signed(bus.data_in2));
      end
      OP_BLTU: begin
        is_branch_c = 1'b1;
        taken_c     = (bus.data_in1 < bus.data_in2);
      end
      OP_BGEU: begin
        is_branch_c = 1'b1;
        taken_c     = (bus.data_in1 >= bus.data_in2);
      end
      default: begin
        taken_c     = 1'b0;
        is_branch_c = 1'b0;
      end
    endcase
    if (!op_defined) begin
      taken_c     = 1'b0;
      is_branch_c = 1'b0;
    end
  end

  assign next_pc_c    = taken_c ? tgt_c : link_c;
  assign pred_pc_c    = bus.pred_taken ? bus.pred_target : link_c;
  assign mispredict_c = (next_pc_c != pred_pc_c);

  // Output register: flush wins, then a new transfer, then drain on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      address_out_q  <= '0;
      link_address_q <= '0;
      taken_q        <= 1'b0;
      mispredict_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      out_valid_q    <= 1'b1;
      address_out_q  <= next_pc_c;
      link_address_q <= link_c;
      taken_q        <= taken_c;
      mispredict_q   <= mispredict_c;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.address_out  = address_out_q;
  assign bus.link_address = link_address_q;
  assign bus.taken        = taken_q;
  assign bus.mispredict   = mispredict_q;

  branch_history_table #(
    .BHT_DEPTH (BHT_DEPTH),
    .BHT_IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_idx   (bus.lookup_pc[BHT_IDX_W+1:2]),
    .lookup_taken (bus.lookup_taken),
    .upd_en       (xfer && is_branch_c),
    .upd_idx      (bus.address_in[BHT_IDX_W+1:2]),
    .upd_taken    (taken_c)
  );

  logic unused_bits;
  assign unused_bits = ^{bus.lookup_pc[XLEN-1:BHT_IDX_W+2], bus.lookup_pc[1:0],
                         jalr_sum[0]};

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Pipelined, parametrised successor to the combinational jump/branch address block. It resolves JAL/JALR/B-type control transfers in one registered stage with a valid/ready handshake, and produces the next PC, the link address, the taken flag and misprediction/redirect information. It also owns a direct-mapped bimodal branch history table (BHT) that fetch reads and resolution trains. It sits between the execute operand mux and the PC/fetch redirect logic.

Parameters:
XLEN, 32, data/address width
OFFSET_SIZE, 12, JALR imm[11:0] and B-type imm[12:1] width
JAL_OFFSET_SIZE, 20, J-type imm[20:1] width
OPERATION_SIZE, 3, opcode select width
BHT_DEPTH, 64, BHT entries; power of two, >=2
BHT_IDX_W, $clog2(BHT_DEPTH), derived, not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  stage can accept
operation  in  OPERATION_SIZE  JAL=0 JALR=1 BEQ=2 BNE=3 BLT=4 BGE=5 BLTU=6 BGEU=7
offset  in  OFFSET_SIZE  JALR imm[11:0] / B-type imm[12:1]
jal_offset  in  JAL_OFFSET_SIZE  J-type imm[20:1]
data_in1  in  XLEN  rs1
data_in2  in  XLEN  rs2
address_in  in  XLEN  PC of the instruction
pred_taken  in  1  fetch prediction for this instruction
pred_target  in  XLEN  fetch predicted target (used only if pred_taken)
flush  in  1  squash the pending result and the current input
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
address_out  out  XLEN  resolved next PC
link_address  out  XLEN  address_in+4
taken  out  1  transfer taken
mispredict  out  1  address_out != predicted next PC
lookup_pc  in  XLEN  fetch PC for the BHT read
lookup_taken  out  1  combinational BHT prediction (counter MSB)

Behaviour:
- Transfer: in_valid && in_ready. in_ready = !flush && (!out_valid || out_ready).
- Latency 1: a transfer at edge N gives registered outputs valid after edge N. Outputs hold stable while out_valid && !out_ready.
- out_valid: set on transfer; cleared on an output handshake with no new transfer; cleared on flush (flush overrides everything that cycle).
- Targets, all arithmetic mod 2^XLEN:
  - JAL: address_in + sext({jal_offset,1'b0}).
  - JALR: (data_in1 + sext(offset)) & ~1.
  - Branch: address_in + sext({offset,1'b0}).
- Compares:
  - BEQ/BNE: equality.
  - BLT/BGE: signed.
  - BLTU/BGEU: unsigned.
- JAL and JALR are always taken. Not taken: address_out = address_in+4.
- Predicted next PC = pred_taken ? pred_target : address_in+4. mispredict = (address_out != predicted next PC); registered with the other outputs.
- Operation codes are 3 bits and all 8 are defined. If OPERATION_SIZE>3, undefined codes resolve as not-taken with no BHT update.
- BHT:
  - BHT_DEPTH x 2-bit saturating counters, index = pc[BHT_IDX_W+1:2].
  - Reset value 2'b01 (weakly not-taken) for every entry.
  - Updated only on transfer of B-type ops (BEQ..BGEU): taken increments, not-taken decrements, saturating at 3 and 0. JAL/JALR never update.
  - lookup_taken = counter[lookup index][1]. A read of the entry being written in the same cycle returns the pre-update value.
- Flush: no transfer and no BHT update that cycle; out_valid=0 next cycle.
- Reset (async, any time incl. mid-transfer): out_valid=0, address_out=0, link_address=0, taken=0, mispredict=0, all BHT entries=2'b01. in_ready=1 once rst_n is high and flush is low.

Decomposition:
- Shared package branch_pkg holds:
  - operation enum typedef (JAL..BGEU, OPERATION_SIZE bits);
  - PC_INCREMENT=4;
  - BHT counter typedef and reset constant 2'b01.
- One sub-module, branch_history_table: counter array, async-read lookup port, saturating update port, async reset.

Test Plan:
1. address_in=0x100, BEQ, offset=12'h004, data 5/5, pred_taken=0 -> next cycle out_valid=1, address_out=0x108, taken=1, mispredict=1, link_address=0x104.
2. BLT vs BLTU with data_in1=0xFFFFFFFF, data_in2=1, address_in=0x200 -> BLT: taken=1, address_out=target. BLTU: taken=0, address_out=0x204.
3. JALR, data_in1=0x2001, offset=0x002, pred_taken=1, pred_target=0x2002 -> address_out=0x2002, mispredict=0. JAL at 0x100 with jal_offset=20'hFFFFE -> address_out=0xFC.
4. out_ready=0 for 3 cycles with in_valid held high -> in_ready=0 and outputs stable; second request accepted on the cycle out_ready rises.
5. Four consecutive taken BNE at PC 0x40 -> lookup_taken(0x40): 0 before, 1 after the first update, counter saturates at 3. Then three not-taken -> lookup_taken=0 and counter=0.
6. Flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0, BHT unchanged. rst_n low mid-stall -> out_valid=0 immediately and all BHT entries read as not-taken.
